// File: rtl/itrx_aib_phy_io_cfg_seq.sv
// itrx_aib_phy_io_cfg_seq: per-IO buffer config/reset sequencer (quiesce, apply, settle, release).
// Optional: ITRX_AIB_PHY_IO_CFG_SEQ_SKIP_SAME_EN lets a cfg_upd that changes nothing stay in ACTIVE.
//
// state   | meaning
// QUIESCE | driver held in reset (iredrstb=0) for QUIESCE_CYC cycles
// APPLY   | shadow config loaded onto txen/rxen, driver still in reset
// SETTLE  | driver released, RX datapath held in reset for SETTLE_CYC cycles
// ACTIVE  | fully enabled; cfg_upd or a pending update restarts the sequence
// BROKEN  | redundancy-broken cell, held quiesced until red_broken falls
module itrx_aib_phy_io_cfg_seq #(
  parameter int QUIESCE_CYC = 4,
  parameter int SETTLE_CYC  = 8,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       cfg_txen,
  input  logic [2:0] cfg_rxen,
  input  logic       cfg_upd,
  input  logic       red_broken,
  output logic       txen,
  output logic [2:0] rxen,
  output logic       iredrstb,
  output logic       rx_irstb,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_err
);

  localparam logic [2:0]       RXEN_NRX = 3'b010;
  localparam logic [CNT_W-1:0] Q_LAST   = CNT_W'(QUIESCE_CYC - 1);
  localparam logic [CNT_W-1:0] S_LAST   = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    ST_QUIESCE,
    ST_APPLY,
    ST_SETTLE,
    ST_ACTIVE,
    ST_BROKEN
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pend, pend_nxt;
  logic             sh_txen, sh_txen_nxt;
  logic [2:0]       sh_rxen, sh_rxen_nxt;
  logic             txen_nxt, iredrstb_nxt, rx_irstb_nxt;
  logic [2:0]       rxen_nxt;
  logic             busy_nxt, done_nxt, err_nxt;
  logic             upd_legal, skip_same;
  logic [2:0]       upd_rxen;

  always_comb begin
    upd_legal = cfg_rxen inside {3'b000, 3'b100, 3'b001, 3'b011, 3'b010};
    upd_rxen  = upd_legal ? cfg_rxen : RXEN_NRX;
  end

`ifdef ITRX_AIB_PHY_IO_CFG_SEQ_SKIP_SAME_EN
  assign skip_same = (cfg_txen == txen) && (upd_rxen == rxen);
`else
  assign skip_same = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    pend_nxt    = pend;
    sh_txen_nxt = sh_txen;
    sh_rxen_nxt = sh_rxen;
    txen_nxt    = txen;
    rxen_nxt    = rxen;
    done_nxt    = 1'b0;
    err_nxt     = cfg_upd & ~upd_legal;

    if (cfg_upd) begin
      sh_txen_nxt = cfg_txen;
      sh_rxen_nxt = upd_rxen;
    end

    if (red_broken) begin
      state_nxt = ST_BROKEN;
      pend_nxt  = 1'b0;
    end else begin
      case (state)
        ST_QUIESCE: if (cnt == Q_LAST) state_nxt = ST_APPLY;
        ST_APPLY: begin
          state_nxt = ST_SETTLE;
          if (cfg_upd) pend_nxt = 1'b1;
        end
        ST_SETTLE: begin
          if (cnt == S_LAST) state_nxt = ST_ACTIVE;
          if (cfg_upd) pend_nxt = 1'b1;
        end
        ST_ACTIVE: begin
          if (pend) begin
            state_nxt = ST_QUIESCE;
            pend_nxt  = 1'b0;
          end else if (cfg_upd) begin
            if (skip_same) done_nxt  = 1'b1;
            else           state_nxt = ST_QUIESCE;
          end
        end
        default: state_nxt = ST_QUIESCE;
      endcase
    end

    // Load uses the _nxt shadow so an update in the last QUIESCE cycle is not lost.
    if (state_nxt == ST_APPLY) begin
      txen_nxt = sh_txen_nxt;
      rxen_nxt = sh_rxen_nxt;
    end else if (state_nxt == ST_BROKEN) begin
      txen_nxt = 1'b0;
      rxen_nxt = RXEN_NRX;
    end

    iredrstb_nxt = (state_nxt == ST_SETTLE) || (state_nxt == ST_ACTIVE);
    rx_irstb_nxt = (state_nxt == ST_ACTIVE);
    busy_nxt     = (state_nxt != ST_ACTIVE);
    if ((state_nxt == ST_ACTIVE) && (state != ST_ACTIVE)) done_nxt = 1'b1;

    if (state_nxt != state) cnt_nxt = '0;
    else if (cnt != '1)     cnt_nxt = cnt + 1'b1;
    else                    cnt_nxt = cnt;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state    <= ST_QUIESCE;
      cnt      <= '0;
      pend     <= 1'b0;
      sh_txen  <= 1'b0;
      sh_rxen  <= RXEN_NRX;
      txen     <= 1'b0;
      rxen     <= RXEN_NRX;
      iredrstb <= 1'b0;
      rx_irstb <= 1'b0;
      cfg_busy <= 1'b1;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pend     <= pend_nxt;
      sh_txen  <= sh_txen_nxt;
      sh_rxen  <= sh_rxen_nxt;
      txen     <= txen_nxt;
      rxen     <= rxen_nxt;
      iredrstb <= iredrstb_nxt;
      rx_irstb <= rx_irstb_nxt;
      cfg_busy <= busy_nxt;
      cfg_done <= done_nxt;
      cfg_err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_itrx_aib_phy_io_cfg_seq.sv
// Scoreboard bench for itrx_aib_phy_io_cfg_seq: timeline reference model feeds expectation queues.
module tb_itrx_aib_phy_io_cfg_seq;
  localparam int Q = 4;
  localparam int S = 8;
  localparam logic [2:0] NRX = 3'b010;
`ifdef ITRX_AIB_PHY_IO_CFG_SEQ_SKIP_SAME_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstb, cfg_txen, cfg_upd, red_broken;
  logic [2:0] cfg_rxen;
  logic txen, iredrstb, rx_irstb, cfg_busy, cfg_done, cfg_err;
  logic [2:0] rxen;

  itrx_aib_phy_io_cfg_seq #(.QUIESCE_CYC(Q), .SETTLE_CYC(S), .CNT_W(4)) dut (
    .clk(clk), .rstb(rstb), .cfg_txen(cfg_txen), .cfg_rxen(cfg_rxen), .cfg_upd(cfg_upd),
    .red_broken(red_broken), .txen(txen), .rxen(rxen), .iredrstb(iredrstb),
    .rx_irstb(rx_irstb), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc; logic txen; logic [2:0] rxen;
    logic ired; logic rxi; logic busy; logic done; logic err;
  } exp_t;
  typedef struct { int cyc; logic txen; logic [2:0] rxen; } done_t;
  exp_t  exp_q[$];
  done_t done_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: the sequence is a timeline measured from the cycle QUIESCE began (m_t0).
  int         m_t0 = 0;
  bit         m_broken = 0, m_pend = 0;
  logic       m_shtx = 0, m_tx = 0;
  logic [2:0] m_shrx = NRX, m_rx = NRX;

  function automatic bit legal(input logic [2:0] r);
    return (r == 3'b000) || (r == 3'b100) || (r == 3'b001) || (r == 3'b011) || (r == 3'b010);
  endfunction

  task automatic model_step(input logic r, input logic u, input logic tx,
                            input logic [2:0] rx, input logic b);
    int k, p, q;
    logic [2:0] srx;
    bit skipdone, err;
    exp_t e;
    done_t d;
    k = cyc + 1;
    p = cyc - m_t0;
    skipdone = 0;
    err = 0;
    srx = legal(rx) ? rx : NRX;
    if (!r) begin
      m_t0 = k; m_broken = 0; m_pend = 0;
      m_shtx = 0; m_shrx = NRX; m_tx = 0; m_rx = NRX;
    end else begin
      err = u && !legal(rx);
      if (u) begin m_shtx = tx; m_shrx = srx; end
      if (b) begin
        m_broken = 1; m_pend = 0; m_tx = 0; m_rx = NRX;
      end else if (m_broken) begin
        m_broken = 0; m_t0 = k;
      end else if (p >= Q && p <= Q + S) begin
        if (u) m_pend = 1;
      end else if (p > Q + S) begin
        if (m_pend) begin
          m_pend = 0; m_t0 = k;
        end else if (u) begin
          if (SKIP && tx == m_tx && srx == m_rx) skipdone = 1;
          else m_t0 = k;
        end
      end
    end
    q = k - m_t0;
    if (!m_broken && q == Q) begin m_tx = m_shtx; m_rx = m_shrx; end
    e.cyc = k; e.txen = m_tx; e.rxen = m_rx; e.err = err;
    if (m_broken) begin
      e.ired = 0; e.rxi = 0; e.busy = 1; e.done = 0;
    end else begin
      e.ired = (q > Q);
      e.rxi  = (q > Q + S);
      e.busy = (q <= Q + S);
      e.done = (q == Q + S + 1) || skipdone;
    end
    exp_q.push_back(e);
    if (e.done) begin
      d.cyc = k; d.txen = m_tx; d.rxen = m_rx;
      done_q.push_back(d);
    end
  endtask

  task automatic drive(input logic r, input logic u, input logic tx,
                       input logic [2:0] rx, input logic b);
    rstb = r; cfg_upd = u; cfg_txen = tx; cfg_rxen = rx; red_broken = b;
    model_step(r, u, tx, rx, b);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'($urandom), 3'($urandom), 1'b0);
  endtask

  // Monitor: per-cycle output compare, cfg_done event compare, and the no-change-while-enabled rule.
  exp_t       mon_e;
  done_t      mon_d;
  logic [3:0] prev_cfg = 4'bxxxx;
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({txen, rxen, iredrstb, rx_irstb, cfg_busy, cfg_done, cfg_err} !==
          {mon_e.txen, mon_e.rxen, mon_e.ired, mon_e.rxi, mon_e.busy, mon_e.done, mon_e.err}) begin
        failures++;
        $display("FAIL outputs cyc=%0d got tx=%b rx=%b ired=%b rxi=%b busy=%b done=%b err=%b exp tx=%b rx=%b ired=%b rxi=%b busy=%b done=%b err=%b",
                 cyc, txen, rxen, iredrstb, rx_irstb, cfg_busy, cfg_done, cfg_err,
                 mon_e.txen, mon_e.rxen, mon_e.ired, mon_e.rxi, mon_e.busy, mon_e.done, mon_e.err);
      end
    end
    if (cfg_done === 1'b1) begin
      checks++;
      if (done_q.size() == 0) begin
        failures++;
        $display("FAIL done_event cyc=%0d got unexpected cfg_done exp none", cyc);
      end else begin
        mon_d = done_q.pop_front();
        if (mon_d.cyc != cyc || mon_d.txen !== txen || mon_d.rxen !== rxen) begin
          failures++;
          $display("FAIL done_event got cyc=%0d tx=%b rx=%b exp cyc=%0d tx=%b rx=%b",
                   cyc, txen, rxen, mon_d.cyc, mon_d.txen, mon_d.rxen);
        end
      end
    end
    if (!$isunknown(prev_cfg) && !$isunknown({txen, rxen}) && {txen, rxen} != prev_cfg) begin
      checks++;
      if (iredrstb !== 1'b0) begin
        failures++;
        $display("FAIL cfg_change_enabled cyc=%0d got iredrstb=%b exp 0", cyc, iredrstb);
      end
    end
    prev_cfg = {txen, rxen};
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit         rb;
    logic       tx;
    logic [2:0] rx;
    repeat (3) drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    idle(20);                                    // reset release sequence
    drive(1'b1, 1'b1, 1'b1, 3'b001, 1'b0);       // update from ACTIVE
    idle(20);
    drive(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    idle(7);
    drive(1'b1, 1'b1, 1'b0, 3'b100, 1'b0);       // lands in SETTLE -> pending
    idle(40);
    drive(1'b1, 1'b1, 1'b1, 3'b111, 1'b0);       // illegal code
    idle(20);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b1);       // broken in ACTIVE
    drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 3'b011, 1'b1);       // captured while broken
    drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
    idle(20);
    drive(1'b1, 1'b1, 1'b1, 3'b011, 1'b0);       // identical config
    idle(20);
    drive(1'b1, 1'b1, 1'b0, 3'b001, 1'b0);
    idle(3);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b1);       // reset mid-sequence, broken ignored
    idle(20);
    rb = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) rb = !rb;
      tx = 1'($urandom);
      rx = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin tx = m_tx; rx = m_rx; end
      drive(($urandom_range(0, 299) != 0), ($urandom_range(0, 7) == 0), tx, rx, rb);
    end
    idle(30);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL exp_queue_drain got %0d left exp 0", exp_q.size());
    end
    checks++;
    if (done_q.size() != 0) begin
      failures++;
      $display("FAIL done_queue_drain got %0d left exp 0", done_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
